// File: rtl/hazard_sequencer.sv
// Pipeline hazard/stall sequencer: chooses advance, hold or bubble per pipeline register
// for load-use, redirect squash and data-memory waits, with a wait timeout and perf counters.
module hazard_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic [4:0]       iIdRs1,
    input  logic [4:0]       iIdRs2,
    input  logic             iIdUseRs1,
    input  logic             iIdUseRs2,
    input  logic [4:0]       iExRd,
    input  logic             iExMemRead,
    input  logic             iExRedirect,
    input  logic             iMemReq,
    input  logic             iMemReady,
    output logic             oPCWrite,
    output logic             oIFIDWrite,
    output logic             oIDEXWrite,
    output logic             oEXMEMWrite,
    output logic             oIFIDFlush,
    output logic             oIDEXFlush,
    output logic             oMEMWBFlush,
    output logic [1:0]       oState,
    output logic             oError,
    output logic [CNT_W-1:0] oStallCycles,
    output logic [CNT_W-1:0] oFlushCount
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_ERROR   = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic memstall;
    logic ldu;
    logic stall_inc;
    logic flush_inc;

    assign memstall = iMemReq & ~iMemReady;
    assign ldu = iExMemRead & (iExRd != 5'd0) &
                 ((iIdUseRs1 & (iIdRs1 == iExRd)) | (iIdUseRs2 & (iIdRs2 == iExRd)));

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        err_d       = err_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        oPCWrite    = 1'b0;
        oIFIDWrite  = 1'b0;
        oIDEXWrite  = 1'b0;
        oEXMEMWrite = 1'b0;
        oIFIDFlush  = 1'b0;
        oIDEXFlush  = 1'b0;
        oMEMWBFlush = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (memstall) begin
                    state_d = ST_MEMWAIT;
                    wait_d  = WAIT_W'(1);
                end
            end
            ST_MEMWAIT: begin
                if (!memstall) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_MAX) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_ERROR: ;
            default: state_d = ST_RUN;
        endcase

        // RUN and MEMWAIT share one action priority; the MEMWAIT release cycle falls through to it
        if (state_q != ST_ERROR) begin
            if (memstall) begin
                oMEMWBFlush = 1'b1;
                stall_inc   = 1'b1;
            end else if (iExRedirect) begin
                oPCWrite    = 1'b1;
                oIFIDWrite  = 1'b1;
                oIDEXWrite  = 1'b1;
                oEXMEMWrite = 1'b1;
                oIFIDFlush  = 1'b1;
                oIDEXFlush  = 1'b1;
                flush_inc   = 1'b1;
            end else if (ldu) begin
                oIDEXWrite  = 1'b1;
                oIDEXFlush  = 1'b1;
                oEXMEMWrite = 1'b1;
                stall_inc   = 1'b1;
            end else begin
                oPCWrite    = 1'b1;
                oIFIDWrite  = 1'b1;
                oIDEXWrite  = 1'b1;
                oEXMEMWrite = 1'b1;
            end
        end

        if (!iRST_n) begin
            oPCWrite    = 1'b0;
            oIFIDWrite  = 1'b0;
            oIDEXWrite  = 1'b0;
            oEXMEMWrite = 1'b0;
            oIFIDFlush  = 1'b0;
            oIDEXFlush  = 1'b0;
            oMEMWBFlush = 1'b0;
        end

        stall_d = (stall_inc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
        flush_d = (flush_inc && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign oState       = state_q;
    assign oError       = err_q;
    assign oStallCycles = stall_q;
    assign oFlushCount  = flush_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed scoreboard bench for hazard_sequencer (TIMEOUT=4, CNT_W=4): expected
// per-cycle outputs are queued by the driver and checked by an independent monitor.
module tb_hazard_sequencer;

    localparam logic [6:0] C_ZERO = 7'b0000_000;
    localparam logic [6:0] C_NORM = 7'b1111_000;
    localparam logic [6:0] C_FRZ  = 7'b0000_001;
    localparam logic [6:0] C_SQ   = 7'b1111_110;
    localparam logic [6:0] C_LDU  = 7'b0011_010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       use1 = 1'b0, use2 = 1'b0, ex_ld = 1'b0, redir = 1'b0;
    logic       mreq = 1'b0, mrdy = 1'b0;
    logic       pcw, ifidw, idexw, exmemw, ifidf, idexf, memwbf, err;
    logic [1:0] st;
    logic [3:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    logic [17:0] exp_q[$];
    int          tag_q[$];

    hazard_sequencer #(.TIMEOUT(4), .CNT_W(4)) dut (
        .iCLK(clk), .iRST_n(rst_n),
        .iIdRs1(id_rs1), .iIdRs2(id_rs2), .iIdUseRs1(use1), .iIdUseRs2(use2),
        .iExRd(ex_rd), .iExMemRead(ex_ld), .iExRedirect(redir),
        .iMemReq(mreq), .iMemReady(mrdy),
        .oPCWrite(pcw), .oIFIDWrite(ifidw), .oIDEXWrite(idexw), .oEXMEMWrite(exmemw),
        .oIFIDFlush(ifidf), .oIDEXFlush(idexf), .oMEMWBFlush(memwbf),
        .oState(st), .oError(err), .oStallCycles(stall_cnt), .oFlushCount(flush_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle the DUT presents a full output word; compare against the queue head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [17:0] e, a;
            int t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {pcw, ifidw, idexw, exmemw, ifidf, idexf, memwbf, st, err, stall_cnt, flush_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL step%0d ctl/state/err/stall/flush actual=%b_%b_%b_%0d_%0d expected=%b_%b_%b_%0d_%0d",
                         t, a[17:11], a[10:9], a[8], a[7:4], a[3:0],
                         e[17:11], e[10:9], e[8], e[7:4], e[3:0]);
            end
        end
    end

    task automatic step(input logic r, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic ld, input logic rdr, input logic mq, input logic mr,
                        input logic [6:0] ctl, input logic [1:0] est, input logic eer,
                        input logic [3:0] esc, input logic [3:0] efc);
        @(posedge clk);
        #1;
        rst_n = r; id_rs1 = rs1; use1 = u1; id_rs2 = rs2; use2 = u2;
        ex_rd = rd; ex_ld = ld; redir = rdr; mreq = mq; mrdy = mr;
        step_no++;
        exp_q.push_back({ctl, est, eer, esc, efc});
        tag_q.push_back(step_no);
    endtask

    task automatic idle(input logic r, input logic [6:0] ctl, input logic [1:0] est,
                        input logic eer, input logic [3:0] esc, input logic [3:0] efc);
        step(r, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, est, eer, esc, efc);
    endtask

    task automatic mem(input logic rdy, input logic rdr, input logic [6:0] ctl,
                       input logic [1:0] est, input logic eer, input logic [3:0] esc,
                       input logic [3:0] efc);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, rdr, 1'b1, rdy, ctl, est, eer, esc, efc);
    endtask

    initial begin
        // Reset held with a load-use pattern present: everything must stay quiet.
        step(1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_ZERO, 2'b00, 1'b0, 4'd0, 4'd0);
        idle(1'b0, C_ZERO, 2'b00, 1'b0, 4'd0, 4'd0);
        idle(1'b1, C_NORM, 2'b00, 1'b0, 4'd0, 4'd0);
        // Load-use on rs2 = x5: one bubble then normal.
        step(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LDU, 2'b00, 1'b0, 4'd0, 4'd0);
        idle(1'b1, C_NORM, 2'b00, 1'b0, 4'd1, 4'd0);
        // Load to x0 never stalls.
        step(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 2'b00, 1'b0, 4'd1, 4'd0);
        // Redirect together with load-use: squash wins, stall count unchanged.
        step(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, C_SQ, 2'b00, 1'b0, 4'd1, 4'd0);
        idle(1'b1, C_NORM, 2'b00, 1'b0, 4'd1, 4'd1);
        // Three memory-wait cycles, release, back in RUN.
        mem(1'b0, 1'b0, C_FRZ, 2'b00, 1'b0, 4'd1, 4'd1);
        mem(1'b0, 1'b0, C_FRZ, 2'b01, 1'b0, 4'd2, 4'd1);
        mem(1'b0, 1'b0, C_FRZ, 2'b01, 1'b0, 4'd3, 4'd1);
        mem(1'b1, 1'b0, C_NORM, 2'b01, 1'b0, 4'd4, 4'd1);
        idle(1'b1, C_NORM, 2'b00, 1'b0, 4'd4, 4'd1);
        // Redirect during freeze is held and taken on the release cycle.
        mem(1'b0, 1'b1, C_FRZ, 2'b00, 1'b0, 4'd4, 4'd1);
        mem(1'b1, 1'b1, C_SQ, 2'b01, 1'b0, 4'd5, 4'd1);
        idle(1'b1, C_NORM, 2'b00, 1'b0, 4'd5, 4'd2);
        // Twenty load-use stalls: counter saturates at 15.
        for (int i = 0; i < 20; i++)
            step(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                 C_LDU, 2'b00, 1'b0, 4'((5 + i > 15) ? 15 : (5 + i)), 4'd2);
        idle(1'b1, C_NORM, 2'b00, 1'b0, 4'd15, 4'd2);
        // Timeout: TIMEOUT+1 = 5 freeze cycles, then ERROR with everything off.
        mem(1'b0, 1'b0, C_FRZ, 2'b00, 1'b0, 4'd15, 4'd2);
        for (int i = 0; i < 4; i++)
            mem(1'b0, 1'b0, C_FRZ, 2'b01, 1'b0, 4'd15, 4'd2);
        mem(1'b0, 1'b0, C_ZERO, 2'b10, 1'b1, 4'd15, 4'd2);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_ZERO, 2'b10, 1'b1, 4'd15, 4'd2);
        mem(1'b1, 1'b0, C_ZERO, 2'b10, 1'b1, 4'd15, 4'd2);
        // Asynchronous reset out of ERROR.
        idle(1'b0, C_ZERO, 2'b00, 1'b0, 4'd0, 4'd0);
        idle(1'b1, C_NORM, 2'b00, 1'b0, 4'd0, 4'd0);
        // Asynchronous reset in the middle of MEMWAIT.
        mem(1'b0, 1'b0, C_FRZ, 2'b00, 1'b0, 4'd0, 4'd0);
        mem(1'b0, 1'b0, C_FRZ, 2'b01, 1'b0, 4'd1, 4'd0);
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_ZERO, 2'b00, 1'b0, 4'd0, 4'd0);
        idle(1'b1, C_NORM, 2'b00, 1'b0, 4'd0, 4'd0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t limit=100000", $time);
        $fatal(1, "watchdog");
    end

endmodule
